// File: rtl/uart_event_packetizer.sv
// rtl/uart_event_packetizer.sv - UART byte stream to EVT2 event word assembler
module uart_event_packetizer #(
  parameter int         COORD_BYTES  = 2,
  parameter int         X_BITS       = 11,
  parameter int         Y_BITS       = 11,
  parameter int         TS_BITS      = 6,
  parameter int         SYNC_EN      = 0,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         CHECKSUM_EN  = 0,
  parameter int         TIMEOUT_CLKS = 2080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [TS_BITS-1:0] ts_now,
  output logic [31:0]        evt_word,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               busy,
  output logic [15:0]        drop_count,
  output logic [15:0]        err_count
);

  typedef enum logic [2:0] {S_SYNC, S_X, S_Y, S_POL, S_CHK} state_t;

  localparam state_t      START    = (SYNC_EN != 0) ? S_SYNC : S_X;
  localparam logic        LAST_IDX = (COORD_BYTES > 1);
  localparam int          IW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [IW:0] TO_LIMIT = (IW + 1)'(TIMEOUT_CLKS);

  state_t             state_q, state_d;
  logic               idx_q, idx_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic               pol_q, pol_d;
  logic [TS_BITS-1:0] ts_q, ts_d;
  logic [7:0]         acc_q, acc_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [31:0]        evt_word_q, evt_word_d;
  logic               evt_valid_q, evt_valid_d;
  logic [15:0]        drop_q, drop_d;
  logic [15:0]        err_q, err_d;

  logic               at_start;
  logic [IW:0]        idle_inc;
  logic               done;
  logic               pkt_err;
  logic [27:0]        x_wide;
  logic [27:0]        y_wide;
  logic               x_oor;
  logic               y_oor;
  logic [31:0]        new_word;

  // The second coordinate byte of a one-field-in-progress packet counts as busy too
  assign at_start   = (state_q == START) && (idx_q == 1'b0);
  assign busy       = !at_start;
  assign evt_word   = evt_word_q;
  assign evt_valid  = evt_valid_q;
  assign drop_count = drop_q;
  assign err_count  = err_q;

  // Next-state: byte parsing, timeout, completion, output slot and counters
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    pol_d       = pol_q;
    ts_d        = ts_q;
    acc_d       = acc_q;
    idle_d      = idle_q;
    evt_word_d  = evt_word_q;
    evt_valid_d = evt_valid_q && !evt_ready;
    drop_d      = drop_q;
    err_d       = err_q;
    done        = 1'b0;
    pkt_err     = 1'b0;
    idle_inc    = {1'b0, idle_q} + 1'b1;

    if (rx_valid) begin
      idle_d = '0;
      case (state_q)
        S_SYNC: begin
          if (rx_data == SYNC_BYTE) state_d = S_X;
        end
        S_X: begin
          acc_d = acc_q ^ rx_data;
          x_d   = (idx_q == 1'b0) ? {8'h00, rx_data} : {x_q[7:0], rx_data};
          if (idx_q == LAST_IDX) begin
            idx_d   = 1'b0;
            state_d = S_Y;
          end else begin
            idx_d = 1'b1;
          end
        end
        S_Y: begin
          acc_d = acc_q ^ rx_data;
          y_d   = (idx_q == 1'b0) ? {8'h00, rx_data} : {y_q[7:0], rx_data};
          if (idx_q == LAST_IDX) begin
            idx_d   = 1'b0;
            state_d = S_POL;
          end else begin
            idx_d = 1'b1;
          end
        end
        S_POL: begin
          acc_d = acc_q ^ rx_data;
          pol_d = rx_data[0];
          ts_d  = ts_now;
          if (CHECKSUM_EN != 0) state_d = S_CHK;
          else                  done    = 1'b1;
        end
        S_CHK: begin
          done = 1'b1;
          if (acc_q != rx_data) pkt_err = 1'b1;
        end
        default: state_d = START;
      endcase
    end else if (!at_start && (TIMEOUT_CLKS != 0)) begin
      // A byte arriving in the same cycle always wins over the timeout
      if (idle_inc >= TO_LIMIT) pkt_err = 1'b1;
      else                      idle_d  = idle_inc[IW-1:0];
    end

    x_wide   = {12'h000, x_d};
    y_wide   = {12'h000, y_d};
    x_oor    = (x_wide >> X_BITS) != 28'd0;
    y_oor    = (y_wide >> Y_BITS) != 28'd0;
    new_word = {3'b000, pol_d, ts_d, x_wide[X_BITS-1:0], y_wide[Y_BITS-1:0]};

    if (done && (x_oor || y_oor)) pkt_err = 1'b1;

    if (pkt_err) begin
      err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      state_d = START;
      idx_d   = 1'b0;
      acc_d   = 8'h00;
      idle_d  = '0;
    end else if (done) begin
      state_d = START;
      idx_d   = 1'b0;
      acc_d   = 8'h00;
      if (evt_valid_q && !evt_ready) begin
        drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
      end else begin
        evt_word_d  = new_word;
        evt_valid_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= START;
      idx_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pol_q       <= 1'b0;
      ts_q        <= '0;
      acc_q       <= '0;
      idle_q      <= '0;
      evt_word_q  <= '0;
      evt_valid_q <= 1'b0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pol_q       <= pol_d;
      ts_q        <= ts_d;
      acc_q       <= acc_d;
      idle_q      <= idle_d;
      evt_word_q  <= evt_word_d;
      evt_valid_q <= evt_valid_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_event_packetizer.sv
// tb/tb_uart_event_packetizer.sv - self-checking bench for uart_event_packetizer
module tb_uart_event_packetizer;

  localparam int N     = 4;
  localparam int D_DEF = 0;
  localparam int D_CHK = 1;
  localparam int D_SYN = 2;
  localparam int D_TO  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic [5:0]    ts_now = 6'h00;
  logic [N-1:0]  rx_valid = '0;
  logic [N-1:0]  evt_ready = '1;
  logic [31:0]   evt_word [N];
  logic [N-1:0]  evt_valid;
  logic [N-1:0]  busy;
  logic [15:0]   drop_count [N];
  logic [15:0]   err_count [N];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_event_packetizer u_def (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[D_DEF]), .ts_now(ts_now),
    .evt_word(evt_word[D_DEF]), .evt_valid(evt_valid[D_DEF]), .evt_ready(evt_ready[D_DEF]),
    .busy(busy[D_DEF]), .drop_count(drop_count[D_DEF]), .err_count(err_count[D_DEF]));

  uart_event_packetizer #(.CHECKSUM_EN(1)) u_chk (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[D_CHK]), .ts_now(ts_now),
    .evt_word(evt_word[D_CHK]), .evt_valid(evt_valid[D_CHK]), .evt_ready(evt_ready[D_CHK]),
    .busy(busy[D_CHK]), .drop_count(drop_count[D_CHK]), .err_count(err_count[D_CHK]));

  uart_event_packetizer #(.SYNC_EN(1)) u_syn (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[D_SYN]), .ts_now(ts_now),
    .evt_word(evt_word[D_SYN]), .evt_valid(evt_valid[D_SYN]), .evt_ready(evt_ready[D_SYN]),
    .busy(busy[D_SYN]), .drop_count(drop_count[D_SYN]), .err_count(err_count[D_SYN]));

  uart_event_packetizer #(.TIMEOUT_CLKS(100)) u_to (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[D_TO]), .ts_now(ts_now),
    .evt_word(evt_word[D_TO]), .evt_valid(evt_valid[D_TO]), .evt_ready(evt_ready[D_TO]),
    .busy(busy[D_TO]), .drop_count(drop_count[D_TO]), .err_count(err_count[D_TO]));

  // Reference: EVT2 word built directly from the field definitions
  function automatic logic [31:0] exp_word(int x, int y, logic pol, logic [5:0] ts);
    logic [10:0] xs;
    logic [10:0] ys;
    xs = x[10:0];
    ys = y[10:0];
    return {3'b000, pol, ts, xs, ys};
  endfunction

  // Reference: XOR of every payload byte
  function automatic logic [7:0] exp_chk(int x, int y, logic [7:0] polb);
    logic [15:0] xv;
    logic [15:0] yv;
    xv = 16'(x);
    yv = 16'(y);
    return xv[15:8] ^ xv[7:0] ^ yv[15:8] ^ yv[7:0] ^ polb;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = '0;
    evt_ready = '1;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; the byte is taken on the following posedge
  task automatic send_byte(int d, logic [7:0] b);
    rx_data = b;
    rx_valid[d] = 1'b1;
    @(negedge clk);
    rx_valid[d] = 1'b0;
  endtask

  task automatic send_packet(int d, int x, int y, logic [7:0] polb, logic [5:0] ts,
                             bit with_chk, logic [7:0] chk, int gap);
    logic [15:0] xv;
    logic [15:0] yv;
    xv = 16'(x);
    yv = 16'(y);
    ts_now = 6'($urandom); send_byte(d, xv[15:8]); repeat (gap) @(negedge clk);
    ts_now = 6'($urandom); send_byte(d, xv[7:0]);  repeat (gap) @(negedge clk);
    ts_now = 6'($urandom); send_byte(d, yv[15:8]); repeat (gap) @(negedge clk);
    ts_now = 6'($urandom); send_byte(d, yv[7:0]);  repeat (gap) @(negedge clk);
    ts_now = ts;
    send_byte(d, polb);
    if (with_chk) begin
      repeat (gap) @(negedge clk);
      ts_now = 6'($urandom);
      send_byte(d, chk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < N; d++) begin
      n_cmp++; if (evt_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %0b want 0", d, evt_valid[d]); end
      n_cmp++; if (evt_word[d] !== 32'h0) begin n_fail++; $display("FAIL reset_word[%0d]: got %h want 0", d, evt_word[d]); end
      n_cmp++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %0b want 0", d, busy[d]); end
      n_cmp++; if (drop_count[d] !== 16'h0) begin n_fail++; $display("FAIL reset_drop[%0d]: got %h want 0", d, drop_count[d]); end
      n_cmp++; if (err_count[d] !== 16'h0) begin n_fail++; $display("FAIL reset_err[%0d]: got %h want 0", d, err_count[d]); end
    end
    send_byte(D_DEF, 8'h00);
    send_byte(D_DEF, 8'h05);
    n_cmp++; if (busy[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL midpkt_busy: got %0b want 1", busy[D_DEF]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b want 0", busy[D_DEF]); end
    n_cmp++; if (err_count[D_DEF] !== 16'h0) begin n_fail++; $display("FAIL midreset_err: got %h want 0", err_count[D_DEF]); end
    send_packet(D_DEF, 7, 9, 8'h01, 6'h11, 0, 8'h00, 0);
    n_cmp++; if (evt_word[D_DEF] !== exp_word(7, 9, 1'b1, 6'h11)) begin n_fail++; $display("FAIL midreset_word: got %h want %h", evt_word[D_DEF], exp_word(7, 9, 1'b1, 6'h11)); end
  endtask

  task automatic test_basic();
    do_reset();
    evt_ready[D_DEF] = 1'b0;
    send_byte(D_DEF, 8'h00);
    send_byte(D_DEF, 8'h05);
    send_byte(D_DEF, 8'h00);
    send_byte(D_DEF, 8'h0A);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", evt_valid[D_DEF]); end
    n_cmp++; if (busy[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy[D_DEF]); end
    ts_now = 6'h2A;
    send_byte(D_DEF, 8'h01);
    ts_now = 6'h00;
    n_cmp++; if (evt_valid[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", evt_valid[D_DEF]); end
    n_cmp++; if (evt_word[D_DEF] !== 32'h1A80280A) begin n_fail++; $display("FAIL basic_word: got %h want 1a80280a", evt_word[D_DEF]); end
    @(negedge clk);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL basic_hold_valid: got %0b want 1", evt_valid[D_DEF]); end
    n_cmp++; if (evt_word[D_DEF] !== 32'h1A80280A) begin n_fail++; $display("FAIL basic_hold_word: got %h want 1a80280a", evt_word[D_DEF]); end
    evt_ready[D_DEF] = 1'b1;
    @(negedge clk);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %0b want 0", evt_valid[D_DEF]); end
    n_cmp++; if (busy[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %0b want 0", busy[D_DEF]); end
  endtask

  task automatic test_range();
    do_reset();
    send_packet(D_DEF, 16'h0800, 1, 8'h00, 6'h05, 0, 8'h00, 0);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL range_x_valid: got %0b want 0", evt_valid[D_DEF]); end
    n_cmp++; if (err_count[D_DEF] !== 16'd1) begin n_fail++; $display("FAIL range_x_err: got %0d want 1", err_count[D_DEF]); end
    n_cmp++; if (busy[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL range_busy: got %0b want 0", busy[D_DEF]); end
    send_packet(D_DEF, 2047, 2047, 8'h01, 6'h3F, 0, 8'h00, 0);
    n_cmp++; if (evt_word[D_DEF] !== exp_word(2047, 2047, 1'b1, 6'h3F)) begin n_fail++; $display("FAIL range_max_word: got %h want %h", evt_word[D_DEF], exp_word(2047, 2047, 1'b1, 6'h3F)); end
    n_cmp++; if (err_count[D_DEF] !== 16'd1) begin n_fail++; $display("FAIL range_max_err: got %0d want 1", err_count[D_DEF]); end
    @(negedge clk);
    send_packet(D_DEF, 3, 2048, 8'h01, 6'h01, 0, 8'h00, 0);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL range_y_valid: got %0b want 0", evt_valid[D_DEF]); end
    n_cmp++; if (err_count[D_DEF] !== 16'd2) begin n_fail++; $display("FAIL range_y_err: got %0d want 2", err_count[D_DEF]); end
  endtask

  task automatic test_checksum();
    do_reset();
    send_packet(D_CHK, 5, 10, 8'h01, 6'h2A, 1, 8'h0E, 0);
    n_cmp++; if (evt_valid[D_CHK] !== 1'b1) begin n_fail++; $display("FAIL chk_good_valid: got %0b want 1", evt_valid[D_CHK]); end
    n_cmp++; if (evt_word[D_CHK] !== 32'h1A80280A) begin n_fail++; $display("FAIL chk_good_word: got %h want 1a80280a", evt_word[D_CHK]); end
    send_packet(D_CHK, 5, 10, 8'h01, 6'h2A, 1, 8'h0F, 0);
    n_cmp++; if (evt_valid[D_CHK] !== 1'b0) begin n_fail++; $display("FAIL chk_bad_valid: got %0b want 0", evt_valid[D_CHK]); end
    n_cmp++; if (err_count[D_CHK] !== 16'd1) begin n_fail++; $display("FAIL chk_bad_err: got %0d want 1", err_count[D_CHK]); end
    send_packet(D_CHK, 16'h0800, 1, 8'h00, 6'h00, 1, 8'h00, 0);
    n_cmp++; if (err_count[D_CHK] !== 16'd2) begin n_fail++; $display("FAIL chk_double_err: got %0d want 2", err_count[D_CHK]); end
    send_packet(D_CHK, 16'h0800, 1, 8'h00, 6'h00, 1, exp_chk(16'h0800, 1, 8'h00), 0);
    n_cmp++; if (evt_valid[D_CHK] !== 1'b0) begin n_fail++; $display("FAIL chk_range_valid: got %0b want 0", evt_valid[D_CHK]); end
    n_cmp++; if (err_count[D_CHK] !== 16'd3) begin n_fail++; $display("FAIL chk_range_err: got %0d want 3", err_count[D_CHK]); end
  endtask

  task automatic test_sync();
    do_reset();
    send_byte(D_SYN, 8'h33);
    n_cmp++; if (busy[D_SYN] !== 1'b0) begin n_fail++; $display("FAIL sync_junk_busy: got %0b want 0", busy[D_SYN]); end
    send_byte(D_SYN, 8'hA5);
    n_cmp++; if (busy[D_SYN] !== 1'b1) begin n_fail++; $display("FAIL sync_busy: got %0b want 1", busy[D_SYN]); end
    send_packet(D_SYN, 5, 10, 8'h00, 6'h15, 0, 8'h00, 0);
    n_cmp++; if (evt_valid[D_SYN] !== 1'b1) begin n_fail++; $display("FAIL sync_valid: got %0b want 1", evt_valid[D_SYN]); end
    n_cmp++; if (evt_word[D_SYN] !== exp_word(5, 10, 1'b0, 6'h15)) begin n_fail++; $display("FAIL sync_word: got %h want %h", evt_word[D_SYN], exp_word(5, 10, 1'b0, 6'h15)); end
    n_cmp++; if (err_count[D_SYN] !== 16'd0) begin n_fail++; $display("FAIL sync_err: got %0d want 0", err_count[D_SYN]); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(D_TO, 8'h00);
    send_byte(D_TO, 8'h05);
    repeat (99) @(negedge clk);
    send_byte(D_TO, 8'h00);
    send_byte(D_TO, 8'h0A);
    ts_now = 6'h07;
    send_byte(D_TO, 8'h01);
    n_cmp++; if (evt_word[D_TO] !== exp_word(5, 10, 1'b1, 6'h07)) begin n_fail++; $display("FAIL to_99_word: got %h want %h", evt_word[D_TO], exp_word(5, 10, 1'b1, 6'h07)); end
    n_cmp++; if (err_count[D_TO] !== 16'd0) begin n_fail++; $display("FAIL to_99_err: got %0d want 0", err_count[D_TO]); end
    send_byte(D_TO, 8'h00);
    send_byte(D_TO, 8'h05);
    repeat (100) @(negedge clk);
    n_cmp++; if (err_count[D_TO] !== 16'd1) begin n_fail++; $display("FAIL to_100_err: got %0d want 1", err_count[D_TO]); end
    n_cmp++; if (busy[D_TO] !== 1'b0) begin n_fail++; $display("FAIL to_100_busy: got %0b want 0", busy[D_TO]); end
    send_packet(D_TO, 7, 9, 8'h01, 6'h2C, 0, 8'h00, 0);
    n_cmp++; if (evt_word[D_TO] !== exp_word(7, 9, 1'b1, 6'h2C)) begin n_fail++; $display("FAIL to_realign_word: got %h want %h", evt_word[D_TO], exp_word(7, 9, 1'b1, 6'h2C)); end
    n_cmp++; if (err_count[D_TO] !== 16'd1) begin n_fail++; $display("FAIL to_realign_err: got %0d want 1", err_count[D_TO]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready[D_DEF] = 1'b0;
    send_packet(D_DEF, 1, 2, 8'h01, 6'h03, 0, 8'h00, 0);
    n_cmp++; if (evt_word[D_DEF] !== exp_word(1, 2, 1'b1, 6'h03)) begin n_fail++; $display("FAIL bp_first_word: got %h want %h", evt_word[D_DEF], exp_word(1, 2, 1'b1, 6'h03)); end
    send_packet(D_DEF, 4, 5, 8'h00, 6'h06, 0, 8'h00, 0);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %0b want 1", evt_valid[D_DEF]); end
    n_cmp++; if (evt_word[D_DEF] !== exp_word(1, 2, 1'b1, 6'h03)) begin n_fail++; $display("FAIL bp_held_word: got %h want %h", evt_word[D_DEF], exp_word(1, 2, 1'b1, 6'h03)); end
    n_cmp++; if (drop_count[D_DEF] !== 16'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_count[D_DEF]); end
    send_byte(D_DEF, 8'h00);
    send_byte(D_DEF, 8'h06);
    send_byte(D_DEF, 8'h00);
    send_byte(D_DEF, 8'h07);
    ts_now = 6'h09;
    evt_ready[D_DEF] = 1'b1;
    send_byte(D_DEF, 8'h01);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b1) begin n_fail++; $display("FAIL bp_swap_valid: got %0b want 1", evt_valid[D_DEF]); end
    n_cmp++; if (evt_word[D_DEF] !== exp_word(6, 7, 1'b1, 6'h09)) begin n_fail++; $display("FAIL bp_swap_word: got %h want %h", evt_word[D_DEF], exp_word(6, 7, 1'b1, 6'h09)); end
    n_cmp++; if (drop_count[D_DEF] !== 16'd1) begin n_fail++; $display("FAIL bp_swap_drop: got %0d want 1", drop_count[D_DEF]); end
    n_cmp++; if (err_count[D_DEF] !== 16'd0) begin n_fail++; $display("FAIL bp_err: got %0d want 0", err_count[D_DEF]); end
    @(negedge clk);
    n_cmp++; if (evt_valid[D_DEF] !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid: got %0b want 0", evt_valid[D_DEF]); end
  endtask

  task automatic test_random();
    int exp_err [2];
    int devs [2];
    do_reset();
    exp_err[0] = 0;
    exp_err[1] = 0;
    devs[0] = D_DEF;
    devs[1] = D_CHK;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 24; p++) begin
        int x;
        int y;
        int gap;
        logic [7:0] polb;
        logic [5:0] ts;
        logic [7:0] chk;
        bit bad;
        bit oor;
        x = $urandom_range(0, 2300);
        y = $urandom_range(0, 2300);
        gap = $urandom_range(0, 3);
        polb = 8'($urandom);
        ts = 6'($urandom);
        bad = (k == 1) && ($urandom_range(0, 3) == 0);
        chk = exp_chk(x, y, polb) ^ (bad ? 8'(1 + $urandom_range(0, 254)) : 8'h00);
        oor = (x >= 2048) || (y >= 2048);
        send_packet(devs[k], x, y, polb, ts, k == 1, chk, gap);
        if (oor || bad) exp_err[k]++;
        n_cmp++; if (evt_valid[devs[k]] !== !(oor || bad)) begin n_fail++; $display("FAIL rand_valid[%0d.%0d]: got %0b want %0b", k, p, evt_valid[devs[k]], !(oor || bad)); end
        if (!(oor || bad)) begin
          n_cmp++; if (evt_word[devs[k]] !== exp_word(x, y, polb[0], ts)) begin n_fail++; $display("FAIL rand_word[%0d.%0d]: got %h want %h", k, p, evt_word[devs[k]], exp_word(x, y, polb[0], ts)); end
        end
        n_cmp++; if (err_count[devs[k]] !== 16'(exp_err[k])) begin n_fail++; $display("FAIL rand_err[%0d.%0d]: got %0d want %0d", k, p, err_count[devs[k]], exp_err[k]); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_checksum();
    test_sync();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_event_packetizer.md
Name: uart_event_packetizer

Overview:
Parametrised UART-byte-to-EVT2 event assembler. It sits between uart_rx and input_fifo in the gradient-map pipeline and generalises the fixed 5-byte raw-sensor packet format. It adds configurable coordinate byte width, an optional sync-byte framing mode, an optional XOR checksum, inter-byte timeout resynchronisation and coordinate range checking. Output is a 32-bit EVT2 word on a valid/ready handshake, plus saturating drop and error counters.

Parameters:
COORD_BYTES, 2, bytes per coordinate field (1 or 2), sent MSB first.
X_BITS, 11, x field width in the output word.
Y_BITS, 11, y field width in the output word.
TS_BITS, 6, timestamp field width; X_BITS+Y_BITS+TS_BITS must equal 28.
SYNC_EN, 0, 1 means each packet is prefixed by SYNC_BYTE.
SYNC_BYTE, 8'hA5, framing byte, used only when SYNC_EN=1.
CHECKSUM_EN, 0, 1 means a trailing XOR checksum byte follows POL.
TIMEOUT_CLKS, 2080, maximum idle cycles between bytes of one packet; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe, rx_data valid
ts_now  input  TS_BITS  free-running timestamp LSBs
evt_word  output  32  {type[3:0], ts, x, y}; type is 4'h1 (ON) or 4'h0 (OFF)
evt_valid  output  1  evt_word holds an unconsumed event
evt_ready  input  1  consumer accepts evt_word when evt_valid && evt_ready
busy  output  1  a packet is partially received (state past the start state)
drop_count  output  16  saturating count of packets lost because the output was full
err_count  output  16  saturating count of checksum, timeout and range errors

Behaviour:
- Reset: all outputs are 0; FSM returns to the start state; field registers and checksum accumulator are cleared. Reset asserted mid-packet discards the partial packet with no counter change.
- Packet byte order is [SYNC]? X[COORD_BYTES] Y[COORD_BYTES] POL [CHK]?. Defaults give the legacy 5-byte format.
- FSM states are S_SYNC, S_X, S_Y, S_POL, S_CHK. The start state is S_SYNC if SYNC_EN=1, else S_X. An internal byte index counts bytes within the X and Y fields.
- S_SYNC: a byte equal to SYNC_BYTE moves the FSM to S_X. Any other byte is silently discarded and does not count as an error.
- S_X and S_Y: shift bytes in MSB first; advance after COORD_BYTES bytes. Every payload byte (X, Y, POL; never SYNC) is XORed into the checksum accumulator.
- S_POL: the type nibble is taken from rx_data[0]. ts is captured from ts_now in the same cycle POL is accepted. Then go to S_CHK if CHECKSUM_EN=1, else the packet is complete.
- S_CHK: if the accumulator does not equal rx_data, err_count increments and the packet is discarded.
- Range check: if the received coordinate value is ≥ 2^X_BITS (or ≥ 2^Y_BITS for y), the packet is discarded at completion and err_count increments once.
- Timeout: an idle counter clears on every rx_valid and is held at 0 in the start state. When it reaches TIMEOUT_CLKS in a cycle without rx_valid, the FSM returns to the start state and err_count increments. If rx_valid and timeout coincide, the byte wins and is processed normally.
- After completion or any error the FSM returns to the start state and the accumulator clears.
- Output latency: evt_valid rises on the cycle after the final byte's rx_valid.
- evt_word holds stable while evt_valid && !evt_ready.
- Completion while evt_valid=1 and evt_ready=0: the new packet is dropped, drop_count increments, and the held word is unchanged.
- Completion in the same cycle the held word is accepted: the new word loads and evt_valid stays 1 with no drop.
- Consumption with no completion: evt_valid clears on the next cycle.
- Counters saturate at 16'hFFFF. Each packet causes at most one increment in total across the two counters.

Test Plan:
1. Defaults; bytes 00 05 00 0A 01 with ts_now=6'h2A on the POL byte → 1 cycle later evt_valid=1, evt_word=32'h1A80280A; with evt_ready=1 it clears after one cycle.
2. Defaults; bytes 08 00 00 01 00 → no evt_valid, err_count=1, busy=0 afterwards.
3. CHECKSUM_EN=1; bytes 00 05 00 0A 01 0E → event emitted. Repeat with CHK=0F → no event, err_count=1.
4. SYNC_EN=1; bytes 33 A5 00 05 00 0A 00 → 33 ignored, one OFF event with x=5, y=10, err_count=0.
5. TIMEOUT_CLKS=100; send 00 05 then idle 100 cycles, then 00 07 00 09 01 → err_count=1; one event with x=7, y=9 (realigned).
6. evt_ready=0; send two complete packets → first word retained, drop_count=1. Then assert evt_ready in the same cycle a third packet completes → third word loaded, drop_count stays 1.
